// File: rtl/serial_subtractor_4_bit.sv
// Nibble-serial WIDTH-bit subtractor (a - b) built on a 4-bit carry-lookahead slice.
// Optional macro SERIAL_SUB_FLAGS_EN enables the zero/negative/overflow flag logic.
`default_nettype none

module serial_subtractor_4_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic [3:0]       a_nib;
  logic [3:0]       nb_nib;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [3:0]       c;
  logic             cout;
  logic [3:0]       sum;
  logic [WIDTH-1:0] diff_n;
  logic             last_step;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_step) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign last_step = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // 4-bit carry-lookahead slice on the current nibble (b already inverted)
  // ---------------------------------------------------------------------------
  always_comb begin
    a_nib  = a_q[{idx_q, 2'b00} +: 4];
    nb_nib = nb_q[{idx_q, 2'b00} +: 4];
    p      = a_nib ^ nb_nib;
    g      = a_nib & nb_nib;

    c[0] = carry_q;
    c[1] = g[0] | (p[0] & carry_q);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carry_q);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry_q);

    sum = p ^ c;

    diff_n                       = diff_q;
    diff_n[{idx_q, 2'b00} +: 4]  = sum;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      nb_q     <= '0;
      carry_q  <= 1'b1;
      idx_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            nb_q    <= ~b;
            carry_q <= 1'b1;
            idx_q   <= '0;
          end
        end
        RUN: begin
          diff_q  <= diff_n;
          carry_q <= cout;
          if (last_step) begin
            borrow_q <= ~cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

  // ---------------------------------------------------------------------------
  // Signed result flags
  // ---------------------------------------------------------------------------
`ifdef SERIAL_SUB_FLAGS_EN
  logic zero_q;
  logic negative_q;
  logic overflow_q;

  // Subtrahend MSB is recovered from the stored inverted operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == RUN && last_step) begin
      zero_q     <= (diff_n == '0);
      negative_q <= diff_n[WIDTH-1];
      overflow_q <= (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_n[WIDTH-1]);
    end
  end

  assign zero     = zero_q;
  assign negative = negative_q;
  assign overflow = overflow_q;
`else
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_4_bit.sv
// Directed self-checking bench for serial_subtractor_4_bit (WIDTH=32, 8 nibble steps).
`default_nettype none

module tb_serial_subtractor_4_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;
  logic        negative;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

`ifdef SERIAL_SUB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  serial_subtractor_4_bit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operand patterns presented every cycle during the back-to-back test.
  function automatic logic [31:0] fa(input int c);
    return 32'h8000_0000 ^ (32'(c) * 32'h0123_4567);
  endfunction

  function automatic logic [31:0] fb(input int c);
    return 32'(c) * 32'h0765_4321 + 32'd1;
  endfunction

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_d, input logic eb,
                        input logic ez, input logic en, input logic eo);
    int lat;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~av;
    b     = av ^ bv;
    check("busy_after_accept", busy, 1'b1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      a = a + 32'h1111_1111;
      b = b - 32'h0101_0101;
    end
    check("latency", lat, 8);
    check("diff", diff, exp_d);
    check("borrow", borrow, eb);
    check("zero", zero, FLAGS_ON ? ez : 1'b0);
    check("negative", negative, FLAGS_ON ? en : 1'b0);
    check("overflow", overflow, FLAGS_ON ? eo : 1'b0);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 1'b0);
    check("busy_back_idle", busy, 1'b0);
    check("diff_held", diff, exp_d);
  endtask

  initial begin
    logic [31:0] ea;
    logic [31:0] eb2;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 32'h0);
    check("rst_borrow", borrow, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset at the 4th RUN edge of an operation in flight.
    @(negedge clk);
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_done", done, 1'b0);
    check("midrun_rst_diff", diff, 32'h0);
    check("midrun_rst_borrow", borrow, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    run_op(32'h0000_000A, 32'h0000_0004, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high: accepts at edges 0,10,20 (accept, 8 RUN, DONE, IDLE).
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a     = fa(c);
      b     = fb(c);
      start = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_done", done, (c % 10) == 8);
      check("b2b_busy", busy, (c % 10) != 9);
      if ((c % 10) == 8) begin
        ea  = fa(c - 8);
        eb2 = fb(c - 8);
        check("b2b_diff", diff, ea - eb2);
        check("b2b_borrow", borrow, ea < eb2);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("b2b_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
